// File: rtl/cpu_bus_responder_if.sv
// Pin bundle between the 6502 core's multiplexed bus, the responder and the
// backing single-cycle memory port. The responder takes the slave view; the
// core-plus-memory side (or a bench) takes the master view.
interface cpu_bus_responder_if;
  // core side
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_oe;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic        phase;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  // status
  logic        bus_err;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_oe, mem_rdata, mem_ack,
    output cpu_data_out, cpu_data_oe, phase,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_oe, mem_rdata, mem_ack,
    input  cpu_data_out, cpu_data_oe, phase,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 6502 core's multiplexed pin bus.
// Rebuilds the 16-bit address over a phase 0 / phase 1 pair, issues one
// access per bus cycle to the memory port or to an 8-byte debug window, and
// returns read data to the core in the following phase 0 (the RESP clk).
module cpu_bus_responder #(
  parameter logic [15:0] DBG_BASE  = 16'hFFF0,
  parameter logic [7:0]  FILL_BYTE = 8'hEA
) (
  input  logic clk,
  input  logic rst_n,
  cpu_bus_responder_if.slave bus
);

  // phase tracking and phase-0 captures
  logic        phase_q;
  logic        hi_valid_q;
  logic [7:0]  addr_hi_q;
  logic [7:0]  wdata_q;

  // memory strobe registers
  logic        mem_req_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  // access in flight during RESP
  logic        resp_q;
  logic        resp_we_q;
  logic        resp_dbg_q;
  logic [2:0]  resp_off_q;
  logic [7:0]  resp_wdata_q;
  logic [7:0]  dbg_rdata_q;

  // debug window state
  logic [15:0] txn_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        sticky_err_q;
  logic [15:0] last_waddr_q;
  logic [7:0]  last_wdata_q;
  logic [7:0]  scratch_q;
  logic        bus_err_q;

  // next-state helpers
  logic [15:0] acc_addr_d;
  logic        acc_dbg_d;
  logic        commit_d;
  logic        resp_end_d;
  logic        read_fail_d;
  logic [7:0]  dbg_rdata_d;
  logic [7:0]  err_cnt_d;
  logic [15:0] txn_cnt_d;

  // The very first phase 1 after reset has no captured high byte, so it
  // must not commit; hi_valid_q gates the commit until a phase 0 is seen.
  assign acc_addr_d  = {addr_hi_q, bus.cpu_addr};
  assign acc_dbg_d   = (acc_addr_d[15:3] == DBG_BASE[15:3]);
  assign commit_d    = phase_q && hi_valid_q;
  assign resp_end_d  = resp_q && !phase_q;
  assign read_fail_d = resp_end_d && !resp_we_q && !resp_dbg_q && !bus.mem_ack;
  assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign txn_cnt_d   = txn_cnt_q + 16'd1;

  // Debug read value, taken from state as it stands before the commit edge.
  always_comb begin
    dbg_rdata_d = 8'h00;
    case (acc_addr_d[2:0])
      3'd0:    dbg_rdata_d = txn_cnt_q[7:0];
      3'd1:    dbg_rdata_d = txn_cnt_q[15:8];
      3'd2:    dbg_rdata_d = err_cnt_q;
      3'd3:    dbg_rdata_d = last_waddr_q[7:0];
      3'd4:    dbg_rdata_d = last_waddr_q[15:8];
      3'd5:    dbg_rdata_d = last_wdata_q;
      3'd6:    dbg_rdata_d = {7'b0, sticky_err_q};
      default: dbg_rdata_d = scratch_q;
    endcase
  end

  // Phase toggle; latch the high address byte and write data at the end of phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b1;
      hi_valid_q <= 1'b0;
      addr_hi_q  <= 8'h00;
      wdata_q    <= 8'h00;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        addr_hi_q  <= bus.cpu_addr;
        wdata_q    <= bus.cpu_data_in;
        hi_valid_q <= 1'b1;
      end
    end
  end

  // Memory strobe: set on a non-debug commit, held for one clk, then cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end else if (commit_d && !acc_dbg_d) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= bus.cpu_oe;
      mem_addr_q  <= acc_addr_d;
      mem_wdata_q <= wdata_q;
    end else begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end
  end

  // Record the committed access for the RESP clk and count transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q       <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_dbg_q   <= 1'b0;
      resp_off_q   <= 3'd0;
      resp_wdata_q <= 8'h00;
      dbg_rdata_q  <= 8'h00;
      txn_cnt_q    <= 16'h0000;
    end else begin
      resp_q <= commit_d;
      if (commit_d) begin
        resp_we_q    <= bus.cpu_oe;
        resp_dbg_q   <= acc_dbg_d;
        resp_off_q   <= acc_addr_d[2:0];
        resp_wdata_q <= wdata_q;
        dbg_rdata_q  <= dbg_rdata_d;
        txn_cnt_q    <= txn_cnt_d;
      end
    end
  end

  // End of RESP: error accounting, last-write capture and debug writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q    <= 1'b0;
      err_cnt_q    <= 8'h00;
      sticky_err_q <= 1'b0;
      last_waddr_q <= 16'h0000;
      last_wdata_q <= 8'h00;
      scratch_q    <= 8'h00;
    end else begin
      bus_err_q <= read_fail_d;
      if (read_fail_d) begin
        err_cnt_q    <= err_cnt_d;
        sticky_err_q <= 1'b1;
      end
      if (resp_end_d && resp_we_q && !resp_dbg_q && bus.mem_ack) begin
        last_waddr_q <= mem_addr_q;
        last_wdata_q <= mem_wdata_q;
      end
      // A debug write and a failing read are never in flight together.
      if (resp_end_d && resp_we_q && resp_dbg_q) begin
        if (resp_off_q == 3'd6 && resp_wdata_q[0]) sticky_err_q <= 1'b0;
        if (resp_off_q == 3'd7)                    scratch_q    <= resp_wdata_q;
      end
    end
  end

  assign bus.phase        = phase_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.cpu_data_oe  = resp_q && !resp_we_q;
  assign bus.cpu_data_out = !(resp_q && !resp_we_q) ? 8'h00 :
                            resp_dbg_q              ? dbg_rdata_q :
                            bus.mem_ack             ? bus.mem_rdata : FILL_BYTE;

endmodule
